// File: rtl/mac_operand_loader_if.sv
// Block-control, memory-read and MAC-operand signals of the operand loader.
// The master modport is the loader's view; slave is the surrounding system's view.
interface mac_operand_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                  ap_start;
    logic                  ap_done;
    logic                  ap_idle;
    logic                  ap_ready;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] count;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_en;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic [DATA_WIDTH-1:0] mac_a;
    logic [DATA_WIDTH-1:0] mac_b;
    logic [DATA_WIDTH-1:0] mac_c;
    logic                  mac_start;
    logic                  mac_done;
    logic [ADDR_WIDTH-1:0] triple_idx;

    modport master (
        input  ap_start, base_addr, count, mem_rd_data, mac_done,
        output ap_done, ap_idle, ap_ready, mem_addr, mem_rd_en,
               mac_a, mac_b, mac_c, mac_start, triple_idx
    );

    modport slave (
        output ap_start, base_addr, count, mem_rd_data, mac_done,
        input  ap_done, ap_idle, ap_ready, mem_addr, mem_rd_en,
               mac_a, mac_b, mac_c, mac_start, triple_idx
    );
endinterface

// File: rtl/mac_operand_loader.sv
// Fetches count (a,b,c) triples from a 1-cycle read memory and issues each to the MAC; 5 cycles per triple
// plus MAC latency. Backpressure is the MAC's done: the next fetch waits for it; all outputs are registered.
module mac_operand_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    mac_operand_loader_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, RD_A, RD_B, RD_C, CAP_C, ISSUE, WAIT, DONE
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] count_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_rd_en_q;
    logic [DATA_WIDTH-1:0] mac_a_q;
    logic [DATA_WIDTH-1:0] mac_b_q;
    logic [DATA_WIDTH-1:0] mac_c_q;
    logic                  mac_start_q;
    logic                  ap_done_q;
    logic                  ap_idle_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            mem_addr_q  <= '0;
            mem_rd_en_q <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_c_q     <= '0;
            mac_start_q <= 1'b0;
            ap_done_q   <= 1'b0;
            ap_idle_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.ap_start) begin
                        ptr_q     <= bus.base_addr;
                        count_q   <= bus.count;
                        idx_q     <= '0;
                        ap_idle_q <= 1'b0;
                        if (bus.count == '0) begin
                            state_q   <= DONE;
                            ap_done_q <= 1'b1;
                        end else begin
                            state_q     <= RD_A;
                            mem_rd_en_q <= 1'b1;
                            mem_addr_q  <= bus.base_addr;
                        end
                    end
                end
                RD_A: begin
                    state_q    <= RD_B;
                    mem_addr_q <= ptr_q + ADDR_WIDTH'(1);
                end
                // Read data lags the address by one cycle, so each capture trails its read state.
                RD_B: begin
                    state_q    <= RD_C;
                    mac_a_q    <= bus.mem_rd_data;
                    mem_addr_q <= ptr_q + ADDR_WIDTH'(2);
                end
                RD_C: begin
                    state_q     <= CAP_C;
                    mac_b_q     <= bus.mem_rd_data;
                    mem_rd_en_q <= 1'b0;
                end
                CAP_C: begin
                    state_q     <= ISSUE;
                    mac_c_q     <= bus.mem_rd_data;
                    mac_start_q <= 1'b1;
                end
                ISSUE: begin
                    state_q     <= WAIT;
                    mac_start_q <= 1'b0;
                end
                WAIT: begin
                    if (bus.mac_done) begin
                        if (idx_q == count_q - ADDR_WIDTH'(1)) begin
                            state_q   <= DONE;
                            ap_done_q <= 1'b1;
                        end else begin
                            state_q     <= RD_A;
                            idx_q       <= idx_q + ADDR_WIDTH'(1);
                            ptr_q       <= ptr_q + ADDR_WIDTH'(3);
                            mem_rd_en_q <= 1'b1;
                            mem_addr_q  <= ptr_q + ADDR_WIDTH'(3);
                        end
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    ap_done_q <= 1'b0;
                    ap_idle_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    mem_rd_en_q <= 1'b0;
                    mac_start_q <= 1'b0;
                    ap_done_q   <= 1'b0;
                    ap_idle_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ap_done    = ap_done_q;
    assign bus.ap_idle    = ap_idle_q;
    assign bus.ap_ready   = ap_idle_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_rd_en  = mem_rd_en_q;
    assign bus.mac_a      = mac_a_q;
    assign bus.mac_b      = mac_b_q;
    assign bus.mac_c      = mac_c_q;
    assign bus.mac_start  = mac_start_q;
    assign bus.triple_idx = idx_q;
endmodule

// File: tb/tb_mac_operand_loader.sv
// Directed bench for mac_operand_loader: 1-cycle memory model, cycle-accurate checks at the falling edge.
module tb_mac_operand_loader;
    logic ap_clk;
    logic ap_rst_n;
    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0;
    int   rd_cnt = 0;
    int   s0;
    int   r0;
    logic [31:0] mem [0:65535];

    mac_operand_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

    mac_operand_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    always @(posedge ap_clk) begin
        if (bus.mem_rd_en === 1'b1) bus.mem_rd_data <= mem[bus.mem_addr];
    end

    always @(negedge ap_clk) begin
        if (bus.mac_start === 1'b1) start_cnt <= start_cnt + 1;
        if (bus.mem_rd_en === 1'b1) rd_cnt <= rd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge ap_clk);
    endtask

    // Called at a falling edge while IDLE; returns at the falling edge of cycle 1.
    task automatic start_run(input logic [15:0] b, input logic [15:0] c);
        bus.base_addr = b;
        bus.count     = c;
        bus.ap_start  = 1'b1;
        next_cycle();
        bus.ap_start  = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (bus.mac_start !== 1'b1 && n < 30) begin
            next_cycle();
            n++;
        end
        chk(tag, 64'(bus.mac_start), 64'd1);
    endtask

    // Finds the ISSUE cycle, checks operands, then returns mac_done after lat cycles.
    task automatic do_triple(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                             input logic [31:0] ec, input logic [15:0] eidx, input int lat);
        wait_start({tag, "_start"});
        chk({tag, "_a"}, 64'(bus.mac_a), 64'(ea));
        chk({tag, "_b"}, 64'(bus.mac_b), 64'(eb));
        chk({tag, "_c"}, 64'(bus.mac_c), 64'(ec));
        chk({tag, "_idx"}, 64'(bus.triple_idx), 64'(eidx));
        next_cycle();
        chk({tag, "_pulse"}, 64'(bus.mac_start), 64'd0);
        for (int k = 1; k < lat; k++) next_cycle();
        bus.mac_done = 1'b1;
        next_cycle();
        bus.mac_done = 1'b0;
    endtask

    initial begin
        ap_rst_n      = 1'b0;
        bus.ap_start  = 1'b0;
        bus.base_addr = '0;
        bus.count     = '0;
        bus.mac_done  = 1'b0;
        mem[16'h0010] = 32'd5;
        mem[16'h0011] = 32'd7;
        mem[16'h0012] = 32'd9;
        for (int i = 0; i < 9; i++) mem[16'h0040 + i] = 32'h101 + i;
        mem[16'hFFFE] = 32'hA;
        mem[16'hFFFF] = 32'hB;
        mem[16'h0000] = 32'hC;
        next_cycle();
        next_cycle();

        chk("rst_idle", 64'(bus.ap_idle), 64'd1);
        chk("rst_ready", 64'(bus.ap_ready), 64'd1);
        chk("rst_done", 64'(bus.ap_done), 64'd0);
        chk("rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
        chk("rst_start", 64'(bus.mac_start), 64'd0);
        chk("rst_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_a", 64'(bus.mac_a), 64'd0);
        chk("rst_idx", 64'(bus.triple_idx), 64'd0);
        ap_rst_n = 1'b1;
        next_cycle();

        // Single triple, cycle by cycle
        start_run(16'h0010, 16'd1);
        chk("t1_c1_rd", 64'(bus.mem_rd_en), 64'd1);
        chk("t1_c1_addr", 64'(bus.mem_addr), 64'h10);
        chk("t1_c1_idle", 64'(bus.ap_idle), 64'd0);
        chk("t1_c1_ready", 64'(bus.ap_ready), 64'd0);
        next_cycle();
        chk("t1_c2_addr", 64'(bus.mem_addr), 64'h11);
        next_cycle();
        chk("t1_c3_rd", 64'(bus.mem_rd_en), 64'd1);
        chk("t1_c3_addr", 64'(bus.mem_addr), 64'h12);
        next_cycle();
        chk("t1_c4_rd", 64'(bus.mem_rd_en), 64'd0);
        chk("t1_c4_start", 64'(bus.mac_start), 64'd0);
        next_cycle();
        chk("t1_c5_start", 64'(bus.mac_start), 64'd1);
        chk("t1_c5_a", 64'(bus.mac_a), 64'd5);
        chk("t1_c5_b", 64'(bus.mac_b), 64'd7);
        chk("t1_c5_c", 64'(bus.mac_c), 64'd9);
        next_cycle();
        chk("t1_c6_start", 64'(bus.mac_start), 64'd0);
        chk("t1_c6_done", 64'(bus.ap_done), 64'd0);
        bus.mac_done = 1'b1;
        next_cycle();
        bus.mac_done = 1'b0;
        chk("t1_c7_done", 64'(bus.ap_done), 64'd1);
        chk("t1_c7_a_hold", 64'(bus.mac_a), 64'd5);
        next_cycle();
        chk("t1_c8_done", 64'(bus.ap_done), 64'd0);
        chk("t1_c8_idle", 64'(bus.ap_idle), 64'd1);

        // Three triples, MAC latency 4
        s0 = start_cnt;
        r0 = rd_cnt;
        start_run(16'h0040, 16'd3);
        do_triple("t2_0", 32'h101, 32'h102, 32'h103, 16'd0, 4);
        chk("t2_mid_done", 64'(bus.ap_done), 64'd0);
        do_triple("t2_1", 32'h104, 32'h105, 32'h106, 16'd1, 4);
        do_triple("t2_2", 32'h107, 32'h108, 32'h109, 16'd2, 4);
        chk("t2_done", 64'(bus.ap_done), 64'd1);
        next_cycle();
        chk("t2_idle", 64'(bus.ap_idle), 64'd1);
        chk("t2_nstart", 64'(start_cnt - s0), 64'd3);
        chk("t2_nreads", 64'(rd_cnt - r0), 64'd9);

        // count = 0
        s0 = start_cnt;
        r0 = rd_cnt;
        start_run(16'h0010, 16'd0);
        chk("t3_c1_done", 64'(bus.ap_done), 64'd1);
        next_cycle();
        chk("t3_c2_done", 64'(bus.ap_done), 64'd0);
        chk("t3_c2_idle", 64'(bus.ap_idle), 64'd1);
        next_cycle();
        chk("t3_nstart", 64'(start_cnt - s0), 64'd0);
        chk("t3_nreads", 64'(rd_cnt - r0), 64'd0);

        // Address wrap-around
        start_run(16'hFFFE, 16'd1);
        chk("t4_addr0", 64'(bus.mem_addr), 64'hFFFE);
        next_cycle();
        chk("t4_addr1", 64'(bus.mem_addr), 64'hFFFF);
        next_cycle();
        chk("t4_addr2", 64'(bus.mem_addr), 64'h0000);
        do_triple("t4", 32'hA, 32'hB, 32'hC, 16'd0, 1);
        chk("t4_done", 64'(bus.ap_done), 64'd1);
        next_cycle();

        // Disturbances: spurious done in RD_B, start during WAIT, reset in RD_C
        start_run(16'h0040, 16'd3);
        next_cycle();
        bus.mac_done = 1'b1;
        next_cycle();
        bus.mac_done = 1'b0;
        chk("t5_c3_addr", 64'(bus.mem_addr), 64'h42);
        chk("t5_c3_rd", 64'(bus.mem_rd_en), 64'd1);
        next_cycle();
        next_cycle();
        chk("t5_c5_start", 64'(bus.mac_start), 64'd1);
        chk("t5_c5_c", 64'(bus.mac_c), 64'h103);
        next_cycle();
        bus.base_addr = 16'h0000;
        bus.count     = 16'd0;
        bus.ap_start  = 1'b1;
        next_cycle();
        chk("t5_wait_idle", 64'(bus.ap_idle), 64'd0);
        chk("t5_wait_done", 64'(bus.ap_done), 64'd0);
        chk("t5_wait_rd", 64'(bus.mem_rd_en), 64'd0);
        bus.ap_start = 1'b0;
        bus.mac_done = 1'b1;
        next_cycle();
        bus.mac_done = 1'b0;
        chk("t5_rda_addr", 64'(bus.mem_addr), 64'h43);
        chk("t5_rda_idx", 64'(bus.triple_idx), 64'd1);
        next_cycle();
        next_cycle();
        chk("t5_rdc_addr", 64'(bus.mem_addr), 64'h45);
        ap_rst_n = 1'b0;
        #1;
        chk("t5_rst_rd", 64'(bus.mem_rd_en), 64'd0);
        chk("t5_rst_addr", 64'(bus.mem_addr), 64'd0);
        chk("t5_rst_idx", 64'(bus.triple_idx), 64'd0);
        chk("t5_rst_a", 64'(bus.mac_a), 64'd0);
        chk("t5_rst_b", 64'(bus.mac_b), 64'd0);
        chk("t5_rst_idle", 64'(bus.ap_idle), 64'd1);
        s0 = start_cnt;
        r0 = rd_cnt;
        next_cycle();
        next_cycle();
        chk("t5_rst_nreads", 64'(rd_cnt - r0), 64'd0);
        chk("t5_rst_nstart", 64'(start_cnt - s0), 64'd0);
        ap_rst_n = 1'b1;
        next_cycle();
        start_run(16'h0010, 16'd1);
        chk("t5_fresh_addr", 64'(bus.mem_addr), 64'h10);
        do_triple("t5_fresh", 32'd5, 32'd7, 32'd9, 16'd0, 2);
        chk("t5_fresh_done", 64'(bus.ap_done), 64'd1);
        next_cycle();
        chk("t5_fresh_idle", 64'(bus.ap_idle), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_operand_loader.md
# mac_operand_loader

Upstream feeder for the pipelined MAC stage. Under HLS-style block control it fetches `count` operand triples (a, b, c) from a single-port, 1-cycle-latency read memory starting at `base_addr`. It presents each triple to the MAC with a one-cycle start pulse, then waits for the MAC's done before fetching the next triple. It asserts `ap_done` once every triple has been issued and acknowledged.

## Interface
- `DATA_WIDTH`, default 32: operand and memory word width.
- `ADDR_WIDTH`, default 16: memory address width; also the width of `count` and the triple index.

Ports:
- `ap_clk`  in  1  single clock; all logic is on the rising edge.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `ap_start`  in  1  starts a run; sampled only in IDLE.
- `ap_done`  out  1  one-cycle pulse when the run completes.
- `ap_idle`  out  1  high while in IDLE.
- `ap_ready`  out  1  high while in IDLE, meaning a new `ap_start` is accepted.
- `base_addr`  in  ADDR_WIDTH  address of the first operand word; latched on an accepted start.
- `count`  in  ADDR_WIDTH  number of triples; latched on an accepted start.
- `mem_addr`  out  ADDR_WIDTH  memory read address.
- `mem_rd_en`  out  1  read strobe; data returns on `mem_rd_data` on the next cycle.
- `mem_rd_data`  in  DATA_WIDTH  read data.
- `mac_a`, `mac_b`, `mac_c`  out  DATA_WIDTH  operands to the MAC.
- `mac_start`  out  1  one-cycle pulse; operands are valid.
- `mac_done`  in  1  MAC completion; sampled only in WAIT.
- `triple_idx`  out  ADDR_WIDTH  index of the current triple.

## Operation
- Memory layout: triple i occupies `base+3i` (a), `base+3i+1` (b) and `base+3i+2` (c). All address arithmetic is modulo 2^ADDR_WIDTH and wraps silently.
- FSM states: IDLE, RD_A, RD_B, RD_C, CAP_C, ISSUE, WAIT, DONE.
- IDLE:
  - On `ap_start`, latch `base_addr` and `count` and clear `triple_idx`.
  - If `count` == 0, go to DONE; otherwise go to RD_A.
- RD_A, RD_B, RD_C: assert `mem_rd_en` with the address of a, b and c respectively.
- Operand capture, one cycle after each read:
  - `mac_a` loads `mem_rd_data` in RD_B.
  - `mac_b` loads `mem_rd_data` in RD_C.
  - `mac_c` loads `mem_rd_data` in CAP_C.
- ISSUE: `mac_start` = 1 for exactly one cycle, then go to WAIT.
- WAIT: hold until `mac_done` = 1. Then:
  - If `triple_idx` == `count`−1, go to DONE.
  - Otherwise increment `triple_idx` and the read pointer by 3, and go to RD_A.
- DONE: `ap_done` = 1 for one cycle, then go to IDLE.
- `mac_a`, `mac_b` and `mac_c` are stable from ISSUE until `mac_done` is accepted. Outside that window they may change.
- `ap_start` outside IDLE is ignored; a run cannot be aborted except by reset.
- A `mac_done` seen outside WAIT, including in the ISSUE cycle, is ignored.
- Reset mid-run:
  - Return to IDLE immediately.
  - All outputs take their reset values; no read or start pulse may be emitted while `ap_rst_n` = 0.
- Reset values:
  - `ap_done`, `mem_rd_en`, `mac_start` = 0.
  - `mem_addr`, `mac_a`, `mac_b`, `mac_c`, `triple_idx` = 0.
  - `ap_idle` and `ap_ready` = 1.

## Timing
- Cycle 0: IDLE with `ap_start` = 1.
- Cycle 1: RD_A, `mem_addr` = base.
- Cycle 2: RD_B, `mem_addr` = base+1; `mac_a` captured.
- Cycle 3: RD_C, `mem_addr` = base+2; `mac_b` captured.
- Cycle 4: CAP_C; `mac_c` captured.
- Cycle 5: ISSUE, `mac_start` = 1.
- Cycle 6: WAIT, at the earliest.
- Per-triple cost is 5 cycles + MAC latency, where MAC latency counts from ISSUE to the cycle `mac_done` is sampled (≥1).
- With `mac_done` in cycle 6 on the last triple: `ap_done` = 1 in cycle 7 and IDLE in cycle 8.
- With `count` = 0: DONE in cycle 1 and IDLE in cycle 2; no memory reads and no `mac_start`.
- All outputs are registered or decoded from the state only; there is no combinational path from inputs to outputs.

## Test plan
- Single triple: base=0x10, count=1, memory {0x10:5, 0x11:7, 0x12:9}, `mac_done` one cycle after ISSUE.
  - Required: reads at 0x10/0x11/0x12 in cycles 1–3.
  - Required: `mac_start` in cycle 5 with a=5, b=7, c=9.
  - Required: `ap_done` in cycle 7.
- Three triples with MAC latency 4: exactly three `mac_start` pulses with triples taken from base, base+3 and base+6. `triple_idx` reads 0, 1, 2, and `ap_done` follows the third `mac_done`.
- count=0: `ap_done` pulses in cycle 1; `mem_rd_en` and `mac_start` never assert.
- Wrap-around: ADDR_WIDTH=16, base=0xFFFE, count=1. Reads go to 0xFFFE, 0xFFFF and 0x0000.
- Mid-run disturbances, checked in one run:
  - `ap_start` re-asserted during WAIT and a spurious `mac_done` during RD_B are both ignored.
  - `ap_rst_n` dropped during RD_C forces the reset values immediately.
  - A fresh start after reset release runs correctly from triple 0.
